// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 active-low keypad scanner. It debounces each key over
// consecutive scans and queues confirmed presses in a 4-deep code FIFO.
module keypad_key_cell #(
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  output logic push
);
  logic       p;
  logic [3:0] c;
  logic       hit;

  assign hit  = ({1'b0, c} + 5'd1) == 5'(DEBOUNCE);
  // Only the press edge of a confirmed change becomes an event.
  assign push = en && (s != p) && hit && s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= 1'b0;
      c <= '0;
    end else if (en) begin
      if (s == p) begin
        c <= '0;
      end else if (hit) begin
        p <= s;
        c <= '0;
      end else begin
        c <= c + 4'd1;
      end
    end
  end
endmodule

module keypad_scan_ctrl #(
  parameter int DWELL    = 16,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       overflow
);
  localparam logic [7:0] T_LAST = 8'(DWELL - 1);
  localparam logic [7:0] T_SAMP = 8'(DWELL - 5);
  localparam logic [7:0] T_EVAL = 8'(DWELL - 4);

  logic [1:0]  r;
  logic [7:0]  t;
  logic [3:0]  meta, sync_col, samp;
  logic        eval_en;
  logic [1:0]  k;
  logic [3:0]  idx;
  logic [15:0] push_vec;
  logic        push_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      t <= '0;
    end else if (t == T_LAST) begin
      t <= '0;
      r <= r + 2'd1;
    end else begin
      t <= t + 8'd1;
    end
  end

  assign row_n = ~(4'b0001 << r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 4'hF;
      sync_col <= 4'hF;
      samp     <= '0;
    end else begin
      meta     <= col_n;
      sync_col <= meta;
      if (t == T_SAMP) samp <= ~sync_col;
    end
  end

  // The last four dwell cycles of each row evaluate its keys, one column per cycle.
  assign eval_en = (t >= T_EVAL);
  assign k       = 2'(t - T_EVAL);
  assign idx     = {r, k};

  generate
    for (genvar i = 0; i < 16; i++) begin : g_key
      keypad_key_cell #(.DEBOUNCE(DEBOUNCE)) u_cell (
        .clk  (clk),
        .rst  (rst),
        .en   (eval_en && (idx == 4'(i))),
        .s    (samp[i % 4]),
        .push (push_vec[i])
      );
    end
  endgenerate

  assign push_req = |push_vec;

  logic [3:0] mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;
  logic       pop, push_ok;

  assign pop     = key_valid && key_ready;
  assign push_ok = push_req && ((count != 3'd4) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= idx;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (push_req && !push_ok) overflow <= 1'b1;
      count <= count + {2'b00, push_ok} - {2'b00, pop};
    end
  end

  assign key_valid = (count != 3'd0);
  // When empty, the slot behind the read pointer is the last code shown.
  assign key_code  = key_valid ? mem[rd_ptr] : mem[rd_ptr - 2'd1];
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a per-scan keypad model with an expected-code
// queue, driven by directed scenarios and random key toggling.
module tb_keypad_scan_ctrl;
  localparam int DW  = 8;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic        overflow;
  logic [15:0] keys = '0;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int first_valid = -1;
  int pops = 0;
  int last_code = 0;
  bit mp [16];
  int mc [16];
  int q [$];
  bit exp_ovf = 1'b0;

  keypad_scan_ctrl #(.DWELL(DW), .DEBOUNCE(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Pressed keys pull their column low while their row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      if (!row_n[rr])
        for (int kk = 0; kk < 4; kk++)
          if (keys[rr*4+kk]) col_n[kk] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One full scan of the spec's debounce rule over the current key image.
  task automatic model_scan();
    for (int i = 0; i < 16; i++) begin
      bit s;
      s = keys[i];
      if (s == mp[i]) mc[i] = 0;
      else if (mc[i] + 1 == DEB) begin
        mp[i] = s;
        mc[i] = 0;
        if (s) begin
          if (!key_ready && q.size() >= 4) exp_ovf = 1'b1;
          else q.push_back(i);
        end
      end else mc[i]++;
    end
  endtask

  task automatic check_pop();
    if (q.size() == 0) begin
      chk("spurious_event", {31'd0, key_valid}, 32'd0);
    end else begin
      int e;
      e = q.pop_front();
      chk("pop_code", {28'd0, key_code}, e);
      last_code = e;
      pops++;
      if (first_valid < 0) first_valid = cyc;
    end
  endtask

  task automatic run_scan(input int pop_at);
    if (pop_at < 0) model_scan();
    for (int i = 0; i < 4*DW; i++) begin
      if (i == pop_at) key_ready = 1'b1;
      if (key_ready && key_valid) check_pop();
      if (i == pop_at) model_scan();
      tick();
      if (i == pop_at) key_ready = 1'b0;
    end
  endtask

  task automatic scans(input int n);
    for (int i = 0; i < n; i++) run_scan(-1);
  endtask

  task automatic do_reset();
    keys = '0;
    key_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_row_n", {28'd0, row_n}, 32'hE);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_code", {28'd0, key_code}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 16; i++) begin mp[i] = 1'b0; mc[i] = 0; end
    exp_ovf = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single press of key 9 with latency check, then a second press.
    key_ready = 1'b1;
    keys[9] = 1'b1;
    first_valid = -1;
    pops = 0;
    begin
      int t0;
      t0 = cyc;
      scans(10);
      chk("press_latency", first_valid - t0, (DEB-1)*4*DW + 2*DW + (DW-4+1) + 1);
    end
    chk("single_event_cnt", pops, 1);
    keys[9] = 1'b0;
    scans(4);
    keys[9] = 1'b1;
    scans(DEB + 1);
    chk("second_event_cnt", pops, 2);
    chk("second_code", last_code, 9);

    // Bounce on key 2 never confirms.
    keys = '0;
    scans(DEB);
    keys[2] = 1'b1; scans(2);
    keys[2] = 1'b0; scans(1);
    keys[2] = 1'b1; scans(2);
    keys[2] = 1'b0; scans(DEB);
    chk("bounce_valid", {31'd0, key_valid}, 32'd0);
    chk("bounce_cnt", pops, 2);

    // Same-row pair: codes 4 then 7.
    keys[4] = 1'b1;
    keys[7] = 1'b1;
    scans(DEB + 1);
    chk("pair_cnt", pops, 4);
    chk("pair_last", last_code, 7);
    keys = '0;
    scans(DEB);

    // Random key toggling against the model.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 2) == 0) begin
        int j;
        j = $urandom_range(0, 15);
        keys[j] = ~keys[j];
      end
      run_scan(-1);
    end
    keys = '0;
    scans(DEB + 1);
    chk("random_drained", q.size(), 0);
    chk("random_no_ovf", {31'd0, overflow}, 32'd0);

    // Reset mid-scan with two codes queued.
    key_ready = 1'b0;
    keys[1] = 1'b1;
    keys[2] = 1'b1;
    scans(DEB + 1);
    chk("pre_rst_valid", {31'd0, key_valid}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    do_reset();
    begin
      int n;
      n = 0;
      while (row_n == 4'b1110 && n < 4*DW) begin tick(); n++; end
      chk("first_row_change", n, DW);
      for (int i = n; i < 4*DW; i++) tick();
    end
    chk("post_rst_valid", {31'd0, key_valid}, 32'd0);

    // Overflow: 0,5,10,15 fill the FIFO, 3 is dropped.
    keys = 16'h8421;
    scans(DEB);
    keys[3] = 1'b1;
    scans(DEB);
    chk("ovf_set", {31'd0, overflow}, {31'd0, exp_ovf});
    chk("ovf_full_valid", {31'd0, key_valid}, 32'd1);
    key_ready = 1'b1;
    pops = 0;
    scans(1);
    chk("ovf_drain_cnt", pops, 4);
    chk("ovf_drain_last", last_code, 15);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_empty", {31'd0, key_valid}, 32'd0);
    chk("code_hold", {28'd0, key_code}, 32'd15);

    // Full FIFO with a pop on the push cycle of code 6.
    do_reset();
    keys = 16'h8421;
    scans(DEB);
    keys[6] = 1'b1;
    scans(DEB - 1);
    run_scan(DW + (DW - 4 + 2));
    chk("full_pop_ovf", {31'd0, overflow}, 32'd0);
    chk("full_pop_valid", {31'd0, key_valid}, 32'd1);
    key_ready = 1'b1;
    pops = 0;
    scans(1);
    chk("full_pop_drain", pops, 4);
    chk("full_pop_last", last_code, 6);
    chk("full_pop_ovf_end", {31'd0, overflow}, 32'd0);
    chk("full_pop_model_q", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for a 4x4 active-low key matrix. It drives one row at a time and samples the columns. Each key is debounced over consecutive scans through a shared per-key state array. Each confirmed press is queued as a 4-bit key code in a small FIFO with a valid/ready consumer port. It sits between the board keypad pins and the CPU input register, replacing per-button debounce instances.

## Interface
- DWELL, 16: clocks each row is driven per scan step; legal range 8..255.
- DEBOUNCE, 8: consecutive disagreeing scan samples needed to change a key's state; legal range 1..15.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- row_n  output  4  row drive, active low, exactly one bit low.
- col_n  input  4  raw column inputs, asynchronous, low = key pressed.
- key_valid  output  1  FIFO non-empty.
- key_code  output  4  head-of-FIFO code = row*4 + col.
- key_ready  input  1  consumer accepts head when key_valid && key_ready.
- overflow  output  1  sticky; set when a confirmed press is dropped; cleared only by rst.

## Operation
- Row index r (2 bits) and dwell counter t (8 bits) run continuously; row_n = ~(1 << r).
- t counts 0..DWELL-1. At t == DWELL-1, t returns to 0 and r increments, wrapping 3 -> 0.
- col_n passes through a 2-flop synchronizer (reset value 4'b1111).
- At t == DWELL-5, latch samp = ~sync_col (1 = pressed).
- Key (r,k) is evaluated at t == DWELL-4+k, for k = 0..3. There is at most one evaluation per cycle.
- Per-key state, 16 entries: pressed bit p and 4-bit count c.
- Evaluation, with s = samp[k]:
  - If s == p: c <= 0.
  - Else if c+1 == DEBOUNCE: p <= s, c <= 0. If s == 1, a push of code {r,k} is requested.
  - Else: c <= c+1.
- Releases never produce events. A held key produces exactly one event.
- FIFO: depth 4, 2-bit read/write pointers plus 3-bit count.
  - A push is accepted if count < 4 or a pop occurs in the same cycle.
  - Otherwise the code is dropped and overflow <= 1.
  - Pop occurs when key_valid && key_ready. Entries leave in arrival order.
- key_code shows the head entry when key_valid = 1. It holds its last value when the FIFO is empty.

## Timing
- Reset values:
  - row_n = 4'b1110, r = 0, t = 0.
  - All p = 0, all c = 0.
  - FIFO empty: key_valid = 0, key_code = 4'h0, overflow = 0.
- Reset asserted mid-scan or mid-transfer discards all queued codes and debounce progress immediately.
- Scan period = 4*DWELL clocks. Column settling allowance = DWELL-5 clocks after the row changes, including synchronizer latency.
- Press latency: the key must read pressed at DEBOUNCE consecutive sample points of its row.
  - key_valid rises on the clock after the final evaluation cycle, when the FIFO was empty.
  - The push is visible the next cycle.
- Pop: key_code advances, or key_valid falls, on the clock after the accepted handshake.
- Simultaneous push and pop:
  - FIFO empty: the pushed code appears on the next cycle.
  - FIFO full: the push is accepted, count stays 4, and overflow is unchanged.
- A bounce shorter than DEBOUNCE samples leaves p unchanged and resets c on the first agreeing sample.

## Test plan
- Reset: assert rst mid-scan with 2 codes queued -> row_n = 1110, key_valid = 0, overflow = 0. After release, the first row change occurs 16 clocks later (DWELL = 16).
- Single press: DWELL = 8, DEBOUNCE = 3. Hold row 2, col 1 pressed for 10 scans -> exactly one event, code 4'd9, valid within 3 scans plus 8 clocks. Release for 4 scans and press again -> second code 9.
- Bounce: DEBOUNCE = 3. Row 0, col 2 pressed for 2 scans, released for 1, pressed for 2, then released -> no event, key_valid stays 0.
- Same-row pair: row 1, col 3 and col 0 pressed together with key_ready = 1 -> codes 4 then 7, on separate cycles, in column order.
- Overflow: key_ready = 0, five distinct keys confirmed (codes 0, 5, 10, 15, 3) -> FIFO holds 0, 5, 10, 15 and overflow = 1. Draining yields the four codes in order; overflow stays 1.
- Full with concurrent pop: FIFO full, key_ready = 1 on the cycle a new press of code 6 is pushed -> no overflow. Drain order is the remaining three codes, then 6.
